sprite_line_renderer: RTL and testbench

Multi-sprite scanline renderer replacing the single-sprite direct-address path in front of the palette BROM and TMDS encoders. Holds a table of NUM_SPRITES sprite descriptors. For each upcoming scanline it fetches palette indices from the external spritesheet BROM into a ping-pong line buffer, applying transparency, priority and right-edge clipping. While that line is being rendered, it streams the previously rendered line out by hcount.

---
 rtl/sprite_line_renderer_if.sv | 39 +++
 rtl/sprite_line_renderer.sv | 121 ++++++++++++
 tb/tb_sprite_line_renderer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/sprite_line_renderer_if.sv
// sprite_line_renderer_if: descriptor, scanline, spritesheet ROM and display signals of the sprite renderer
interface sprite_line_renderer_if #(
  parameter int NUM_SPRITES = 8,
  parameter int SPRITE_W = 64,
  parameter int SPRITE_H = 64,
  parameter int NUM_FRAMES = 512,
  parameter int WIDTH = 1280,
  parameter int HEIGHT = 720,
  parameter int PALETTE_WIDTH = 3
) ();
  localparam int IW = $clog2(NUM_SPRITES);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int FW = $clog2(NUM_FRAMES);
  localparam int AW = $clog2(NUM_FRAMES * SPRITE_W * SPRITE_H);
  logic cfg_we;
  logic [IW-1:0] cfg_idx;
  logic cfg_en;
  logic [XW-1:0] cfg_x;
  logic [YW-1:0] cfg_y;
  logic [FW-1:0] cfg_frame;
  logic line_start;
  logic [YW-1:0] line_y;
  logic [XW-1:0] hcount;
  logic active_draw;
  logic [AW-1:0] rom_addr;
  logic [PALETTE_WIDTH-1:0] rom_data;
  logic [PALETTE_WIDTH-1:0] pix_index;
  logic busy;
  logic overrun;
  modport master (
    output cfg_we, cfg_idx, cfg_en, cfg_x, cfg_y, cfg_frame, line_start, line_y, hcount, active_draw, rom_data,
    input rom_addr, pix_index, busy, overrun
  );
  modport slave (
    input cfg_we, cfg_idx, cfg_en, cfg_x, cfg_y, cfg_frame, line_start, line_y, hcount, active_draw, rom_data,
    output rom_addr, pix_index, busy, overrun
  );
endinterface

// File: rtl/sprite_line_renderer.sv
// sprite_line_renderer: multi-sprite scanline renderer into a ping-pong line buffer streamed out by hcount
module sprite_line_renderer #(
  parameter int NUM_SPRITES = 8,
  parameter int SPRITE_W = 64,
  parameter int SPRITE_H = 64,
  parameter int NUM_FRAMES = 512,
  parameter int WIDTH = 1280,
  parameter int HEIGHT = 720,
  parameter int PALETTE_WIDTH = 3,
  parameter int ROM_LATENCY = 2
) (
  input logic clk_pixel,
  input logic sys_rst,
  sprite_line_renderer_if.slave bus
);
  localparam int IW = $clog2(NUM_SPRITES);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int FW = $clog2(NUM_FRAMES);
  localparam int AW = $clog2(NUM_FRAMES * SPRITE_W * SPRITE_H);
  localparam int CW = $clog2(SPRITE_W);
  localparam int RW = $clog2(SPRITE_H);
  localparam int DW = $clog2(ROM_LATENCY + 1);
  localparam int PW = PALETTE_WIDTH;
  typedef enum logic [2:0] {CLEAR, IDLE, CHECK, FETCH, DRAIN} state_t;
  state_t state, state_d;
  logic [NUM_SPRITES-1:0] spr_en;
  logic [XW-1:0] spr_x [NUM_SPRITES];
  logic [YW-1:0] spr_y [NUM_SPRITES];
  logic [FW-1:0] spr_f [NUM_SPRITES];
  logic [PW-1:0] lb [2][WIDTH];
  logic front, a1;
  logic [XW-1:0] clr, h1, cur_x;
  logic [IW-1:0] s;
  logic [YW-1:0] cur_y;
  logic [FW-1:0] cur_f;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [DW-1:0] cnt;
  logic [ROM_LATENCY:0] tv;
  logic [XW:0] tx [ROM_LATENCY+1];
  logic hit, start, abort, wb;
  assign hit = spr_en[s] && {1'b0, cur_y} >= {1'b0, spr_y[s]}
            && {1'b0, cur_y} < {1'b0, spr_y[s]} + (YW+1)'(SPRITE_H);
  assign start = bus.line_start && state != CLEAR;
  assign abort = start && state != IDLE;
  assign wb = tv[ROM_LATENCY] && !abort && bus.rom_data != '0 && tx[ROM_LATENCY] < (XW+1)'(WIDTH);
  assign bus.busy = state != IDLE;
  always_comb begin
    state_d = state;
    case (state)
      CLEAR: state_d = clr == XW'(WIDTH - 1) ? IDLE : CLEAR;
      CHECK: state_d = hit ? FETCH : (s == '0 ? IDLE : CHECK);
      FETCH: state_d = col == CW'(SPRITE_W - 1) ? DRAIN : FETCH;
      DRAIN: state_d = cnt == DW'(ROM_LATENCY - 1) ? (s == '0 ? IDLE : CHECK) : DRAIN;
      default: ;
    endcase
    if (start) state_d = CHECK;
  end
  always_ff @(posedge clk_pixel) begin
    if (sys_rst) begin
      state <= CLEAR;
      spr_en <= '0;
      front <= 1'b0;
      clr <= '0;
      a1 <= 1'b0;
      h1 <= '0;
      tv <= '0;
      s <= '0;
      cur_y <= '0;
      cur_x <= '0;
      cur_f <= '0;
      row <= '0;
      col <= '0;
      cnt <= '0;
      bus.overrun <= 1'b0;
      bus.rom_addr <= '0;
      bus.pix_index <= '0;
    end else begin
      state <= state_d;
      if (bus.cfg_we) spr_en[bus.cfg_idx] <= bus.cfg_en;
      clr <= clr + XW'(1);
      a1 <= bus.active_draw;
      h1 <= bus.hcount;
      bus.pix_index <= a1 ? lb[front][h1] : '0;
      bus.overrun <= bus.overrun | abort;
      tv <= abort ? '0 : {tv[ROM_LATENCY-1:0], state == FETCH};
      col <= state == FETCH ? col + CW'(1) : '0;
      cnt <= state == DRAIN ? cnt + DW'(1) : '0;
      if (start) begin
        front <= !front;
        cur_y <= bus.line_y;
        s <= IW'(NUM_SPRITES - 1);
      end else if (((state == CHECK && !hit) || (state == DRAIN && state_d != DRAIN)) && s != '0)
        s <= s - IW'(1);
      if (state == CHECK && hit) begin
        row <= RW'(cur_y - spr_y[s]);
        cur_x <= spr_x[s];
        cur_f <= spr_f[s];
      end
      if (state == FETCH)
        bus.rom_addr <= AW'(cur_f) * AW'(SPRITE_W * SPRITE_H) + AW'(row) * AW'(SPRITE_W) + AW'(col);
    end
  end
  always_ff @(posedge clk_pixel) begin
    if (bus.cfg_we) begin
      spr_x[bus.cfg_idx] <= bus.cfg_x;
      spr_y[bus.cfg_idx] <= bus.cfg_y;
      spr_f[bus.cfg_idx] <= bus.cfg_frame;
    end
    tx[0] <= (XW+1)'(cur_x) + (XW+1)'(col);
    for (int i = 1; i <= ROM_LATENCY; i++) tx[i] <= tx[i-1];
    if (state == CLEAR) begin
      lb[0][clr] <= '0;
      lb[1][clr] <= '0;
    end else begin
      if (wb) lb[!front][tx[ROM_LATENCY][XW-1:0]] <= bus.rom_data;
      if (a1) lb[front][h1] <= '0;
    end
  end
endmodule

// File: tb/tb_sprite_line_renderer.sv
// tb_sprite_line_renderer: directed scanline scenarios checked by a pixel scoreboard
module tb_sprite_line_renderer;
  localparam int W = 1280;
  typedef struct {int col; int val;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  sprite_line_renderer_if bus ();
  sprite_line_renderer dut (.clk_pixel(clk), .sys_rst(rst), .bus(bus));
  int tests = 0, fails = 0, mode = 0;
  int exp_new[W], exp_front[W], exp_back[W];
  exp_t sb[$];
  exp_t e;
  int rom_log[$];
  logic log_en = 1'b0;
  logic [20:0] last_addr = '0;
  logic chk = 1'b0;
  logic [1:0] chk_d = '0;
  logic [2:0] d1 = '0, d2 = '0;
  function automatic logic [2:0] rom_fn(int a);
    int col, row, fr;
    col = a % 64;
    row = (a / 64) % 64;
    fr = a / 4096;
    case (mode)
      0: return 3'(col % 8);
      1: return fr == 5 ? ((col % 2 == 0) ? 3'd5 : 3'd0) : 3'd2;
      2: return 3'd7;
      default: return 3'((col + row) % 8);
    endcase
  endfunction
  always @(posedge clk) begin
    d1 <= rom_fn(int'(bus.rom_addr));
    d2 <= d1;
    chk_d <= {chk_d[0], chk};
  end
  assign bus.rom_data = d2;
  task automatic check(string name, int got, int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (chk_d[1]) begin
      if (sb.size() == 0) check("scoreboard_underflow", sb.size(), 1);
      else begin
        e = sb.pop_front();
        check($sformatf("pix[%0d]", e.col), int'(bus.pix_index), e.val);
      end
    end
    if (log_en && bus.rom_addr != last_addr) begin
      rom_log.push_back(int'(bus.rom_addr));
      last_addr = bus.rom_addr;
    end
  end
  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic cfg(int idx, bit en, int x, int y, int f);
    bus.cfg_we = 1'b1;
    bus.cfg_idx = 3'(idx);
    bus.cfg_en = en;
    bus.cfg_x = 11'(x);
    bus.cfg_y = 10'(y);
    bus.cfg_frame = 9'(f);
    tick();
    bus.cfg_we = 1'b0;
  endtask
  task automatic clear_new();
    foreach (exp_new[i]) exp_new[i] = 0;
  endtask
  task automatic start(int y);
    bus.line_start = 1'b1;
    bus.line_y = 10'(y);
    exp_front = exp_back;
    exp_back = exp_new;
    tick();
    bus.line_start = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 4000) begin
      tick();
      n++;
    end
    check("render_done", int'(bus.busy), 0);
  endtask
  task automatic display(bit c);
    for (int h = 0; h < W; h++) begin
      bus.hcount = 11'(h);
      bus.active_draw = 1'b1;
      chk = c;
      if (c) sb.push_back('{h, exp_front[h]});
      tick();
    end
    bus.active_draw = 1'b0;
    chk = 1'b0;
    tick(3);
  endtask
  task automatic line(int y, bit c);
    start(y);
    wait_idle();
    display(c);
  endtask
  initial begin
    bus.cfg_we = 1'b0;
    bus.cfg_idx = '0;
    bus.cfg_en = 1'b0;
    bus.cfg_x = '0;
    bus.cfg_y = '0;
    bus.cfg_frame = '0;
    bus.line_start = 1'b0;
    bus.line_y = '0;
    bus.hcount = '0;
    bus.active_draw = 1'b0;
    clear_new();
    exp_front = exp_new;
    exp_back = exp_new;
    tick(3);
    rst = 1'b0;
    check("rst_rom_addr", int'(bus.rom_addr), 0);
    check("rst_pix", int'(bus.pix_index), 0);
    check("rst_overrun", int'(bus.overrun), 0);
    check("clear_busy_start", int'(bus.busy), 1);
    tick(1279);
    check("clear_busy_last", int'(bus.busy), 1);
    tick();
    check("clear_done", int'(bus.busy), 0);
    cfg(0, 1, 100, 10, 3);
    mode = 0;
    clear_new();
    for (int c = 0; c < 64; c++) exp_new[100 + c] = c % 8;
    last_addr = bus.rom_addr;
    log_en = 1'b1;
    start(12);
    wait_idle();
    log_en = 1'b0;
    display(1);
    check("rom_log_len", rom_log.size(), 64);
    foreach (rom_log[i]) check($sformatf("rom_addr[%0d]", i), rom_log[i], 12416 + i);
    clear_new();
    line(700, 1);
    cfg(0, 1, 200, 0, 5);
    cfg(1, 1, 200, 0, 1);
    mode = 1;
    clear_new();
    for (int c = 0; c < 64; c++) exp_new[200 + c] = (c % 2 == 0) ? 5 : 2;
    line(30, 1);
    clear_new();
    line(700, 1);
    cfg(0, 0, 0, 0, 0);
    cfg(1, 0, 0, 0, 0);
    cfg(2, 1, 1250, 100, 0);
    mode = 2;
    clear_new();
    for (int c = 0; c < 30; c++) exp_new[1250 + c] = 7;
    line(120, 1);
    clear_new();
    line(700, 1);
    line(700, 1);
    for (int i = 0; i < 8; i++) cfg(i, 1, i * 100, 200, i);
    mode = 3;
    clear_new();
    start(210);
    tick(100);
    check("busy_before_abort", int'(bus.busy), 1);
    check("overrun_before_abort", int'(bus.overrun), 0);
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < 64; c++) exp_new[i * 100 + c] = (c + 50) % 8;
    start(250);
    check("overrun_set", int'(bus.overrun), 1);
    wait_idle();
    display(0);
    clear_new();
    line(700, 1);
    check("overrun_sticky", int'(bus.overrun), 1);
    start(230);
    tick(20);
    check("busy_mid_fetch", int'(bus.busy), 1);
    rst = 1'b1;
    tick();
    check("midrst_rom_addr", int'(bus.rom_addr), 0);
    check("midrst_pix", int'(bus.pix_index), 0);
    check("midrst_overrun", int'(bus.overrun), 0);
    check("midrst_clear_busy", int'(bus.busy), 1);
    rst = 1'b0;
    clear_new();
    exp_front = exp_new;
    exp_back = exp_new;
    wait_idle();
    line(230, 1);
    line(230, 1);
    tick(5);
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
